bcd_down_timer: RTL and testbench

- Multi-digit BCD countdown timer for the counter lab board; the down-counting counterpart to the up-counter chain.
- Loads a BCD preset, decrements once per enabled tick and stops at zero, asserting a one-cycle DONE pulse.
- Drives the seven-segment display path and LED done indicator; cascades digits by internal borrow chaining, not external gates.

---
 rtl/bcd_down_timer_pkg.sv | 17 +
 rtl/bcd_down_digit.sv | 29 ++
 rtl/bcd_down_timer.sv | 115 +++++++++++
 tb/tb_bcd_down_timer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_down_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package bcd_down_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown chain: loads a clamped value, decrements with wrap 0->9.
module bcd_down_digit
  import bcd_down_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_in,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [3:0] digit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= '0;
    end else if (load) begin
      digit_q <= clamp_bcd(load_val);
    end else if (dec_in) begin
      digit_q <= (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  assign digit      = digit_q;
  assign borrow_out = dec_in && (digit_q == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with prescaler, pause and registered DONE pulse.
// Optional macro BCD_TIMER_AUTO_RELOAD_EN: reload the last preset on expiry and keep running.
module bcd_down_timer
  import bcd_down_timer_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                LOAD,
  input  logic [4*DIGITS-1:0] PRESET,
  input  logic                START,
  output logic [4*DIGITS-1:0] COUNT,
  output logic                RUNNING,
  output logic                DONE,
  output logic                ZERO
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_t          state, state_next;
  logic [PW-1:0]   presc;
  logic [DIGITS:0] borrow;
  logic [CW-1:0]   count, load_val, reload_val;
  logic            tick, expire_evt, underflow, digit_load, reload_ok;
  logic            done_arm, done_q, running_q;

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic [CW-1:0] preset_keep;

  always_ff @(posedge clk) begin
    if (rst) begin
      preset_keep <= '0;
    end else if (LOAD) begin
      preset_keep <= PRESET;
    end
  end

  assign reload_ok  = (preset_keep != '0);
  assign reload_val = preset_keep;
`else
  assign reload_ok  = 1'b0;
  assign reload_val = '0;
`endif

  assign ZERO       = (count == '0);
  assign tick       = (state == RUN) && START && (presc == PRESC_MAX);
  assign expire_evt = tick && (count == CW'(1));

  // A borrow out of the top digit means a tick hit an all-zero count: instead of
  // wrapping, the chain is reloaded (stored preset with auto-reload, else zero).
  assign borrow[0]  = tick;
  assign underflow  = borrow[DIGITS];
  assign digit_load = LOAD || underflow;
  assign load_val   = LOAD ? PRESET : reload_val;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .load       (digit_load),
      .load_val   (load_val[4*g +: 4]),
      .dec_in     (borrow[g]),
      .digit      (count[4*g +: 4]),
      .borrow_out (borrow[g+1])
    );
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (START && !ZERO) state_next = RUN;
      RUN: begin
        if (!START)                       state_next = PAUSE;
        else if (expire_evt && !reload_ok) state_next = EXPIRED;
      end
      PAUSE:   if (START)  state_next = RUN;
      EXPIRED: if (!START) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (LOAD) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      presc     <= '0;
      running_q <= 1'b0;
      done_arm  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_next;
      running_q <= (state_next == RUN);
      if (LOAD) begin
        presc    <= '0;
        done_arm <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        if ((state == RUN) && START) begin
          presc <= tick ? '0 : presc + 1'b1;
        end
        done_arm <= expire_evt;
        done_q   <= done_arm;
      end
    end
  end

  assign COUNT   = count;
  assign RUNNING = running_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer: a 2-digit fast instance and a 4-digit prescaled instance.
module tb_bcd_down_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_load, f_start, f_running, f_done, f_zero;
  logic [7:0]  f_preset, f_count;
  logic        s_load, s_start, s_running, s_done, s_zero;
  logic [15:0] s_preset, s_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_down_timer #(.DIGITS(2), .TICK_DIV(1)) u_fast (
    .clk(clk), .rst(rst), .LOAD(f_load), .PRESET(f_preset), .START(f_start),
    .COUNT(f_count), .RUNNING(f_running), .DONE(f_done), .ZERO(f_zero)
  );

  bcd_down_timer #(.DIGITS(4), .TICK_DIV(4)) u_slow (
    .clk(clk), .rst(rst), .LOAD(s_load), .PRESET(s_preset), .START(s_start),
    .COUNT(s_count), .RUNNING(s_running), .DONE(s_done), .ZERO(s_zero)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bcd2(input int n);
    logic [7:0] b;
    b[7:4] = 4'(n / 10);
    b[3:0] = 4'(n % 10);
    return b;
  endfunction

  initial begin
    rst = 1'b1;
    f_load = 1'b0; f_start = 1'b0; f_preset = '0;
    s_load = 1'b0; s_start = 1'b0; s_preset = '0;
    step(); step();
    check("rst_count", f_count, 0);
    check("rst_zero", f_zero, 1);
    check("rst_running", f_running, 0);
    check("rst_done", f_done, 0);
    check("rst_count_s", s_count, 0);
    rst = 1'b0;

    // Basic count 12 -> 00 at one tick per cycle
    f_load = 1'b1; f_preset = 8'h12;
    step();
    f_load = 1'b0; f_start = 1'b1;
    check("load_12", f_count, 8'h12);
    check("idle_running", f_running, 0);
    step();
    check("run_entry_count", f_count, 8'h12);
    check("run_entry_running", f_running, 1);
    for (int n = 11; n >= 1; n--) begin
      step();
      check("basic_count", f_count, bcd2(n));
      check("basic_running", f_running, 1);
      check("basic_done", f_done, 0);
      check("basic_zero", f_zero, 0);
    end
    step();
    check("reach_00", f_count, 8'h00);
    check("reach_00_zero", f_zero, 1);
    check("reach_00_done", f_done, 0);
    step();
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    check("reload_count", f_count, 8'h12);
    check("reload_done", f_done, 1);
    check("reload_running", f_running, 1);
    step();
    check("reload_next", f_count, 8'h11);
    check("reload_done_end", f_done, 0);
`else
    check("expired_count", f_count, 8'h00);
    check("expired_done", f_done, 1);
    check("expired_running", f_running, 0);
    step();
    check("expired_hold", f_count, 8'h00);
    check("expired_done_end", f_done, 0);
`endif

    // Clamp of invalid BCD digit
    f_start = 1'b0; f_load = 1'b1; f_preset = 8'h3F;
    step();
    f_load = 1'b0;
    check("clamp_3f", f_count, 8'h39);

    // LOAD coincident with a tick
    f_start = 1'b1;
    step();
    step();
    check("pre_collision", f_count, 8'h38);
    f_load = 1'b1; f_preset = 8'h55;
    step();
    check("collision_count", f_count, 8'h55);
    check("collision_running", f_running, 0);
    check("collision_done", f_done, 0);
    f_load = 1'b0;
    step();
    check("rearm_count", f_count, 8'h55);
    check("rearm_running", f_running, 1);
    step();
    check("rearm_dec", f_count, 8'h54);
    f_start = 1'b0;
    step();

    // START with a zero count does not leave IDLE
    f_load = 1'b1; f_preset = 8'h00;
    step();
    f_load = 1'b0; f_start = 1'b1;
    step(); step();
    check("zero_start_running", f_running, 0);
    check("zero_start_count", f_count, 8'h00);
    f_start = 1'b0;

    // Expiry from preset 03
    f_load = 1'b1; f_preset = 8'h03;
    step();
    f_load = 1'b0; f_start = 1'b1;
    step();
    step(); check("p03_02", f_count, 8'h02);
    step(); check("p03_01", f_count, 8'h01);
    step(); check("p03_00", f_count, 8'h00);
    check("p03_00_done", f_done, 0);
    step();
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    check("p03_wrap", f_count, 8'h03);
    check("p03_wrap_done", f_done, 1);
    step();
    check("p03_wrap_next", f_count, 8'h02);
    check("p03_wrap_done_end", f_done, 0);
`else
    check("p03_stop", f_count, 8'h00);
    check("p03_stop_done", f_done, 1);
    step();
    check("p03_stop_hold", f_count, 8'h00);
    check("p03_stop_done_end", f_done, 0);
`endif
    f_start = 1'b0;

    // Borrow chain on 4 digits, TICK_DIV=4
    s_load = 1'b1; s_preset = 16'h1000;
    step();
    s_load = 1'b0;
    check("s_load_1000", s_count, 16'h1000);
    s_start = 1'b1;
    step();
    step(); step(); step();
    check("s_prescale_hold", s_count, 16'h1000);
    step();
    check("borrow_1000", s_count, 16'h0999);
    s_start = 1'b0; s_load = 1'b1; s_preset = 16'h0100;
    step();
    s_load = 1'b0; s_start = 1'b1;
    check("s_load_0100", s_count, 16'h0100);
    step();
    step(); step(); step(); step();
    check("borrow_0100", s_count, 16'h0099);

    // Pause mid-prescale and resume
    step(); step();
    s_start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("pause_count", s_count, 16'h0099);
    check("pause_running", s_running, 0);
    s_start = 1'b1;
    step();
    check("resume_count", s_count, 16'h0099);
    check("resume_running", s_running, 1);
    step();
    check("resume_wait", s_count, 16'h0099);
    step();
    check("resume_tick", s_count, 16'h0098);
    step(); step(); step();
    check("resume_period", s_count, 16'h0098);
    step();
    check("resume_next_tick", s_count, 16'h0097);
    check("s_done_quiet", s_done, 0);
    check("s_zero_quiet", s_zero, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
